gold_silver_tagger: RTL and testbench

//  Priority-tag stage directly upstream of the MinBD arbiters. Each cycle it takes the

---
 rtl/gold_silver_tagger.sv | 106 ++++++++++
 tb/tb_gold_silver_tagger.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gold_silver_tagger.sv
// Tags each router input with gold, silver and random tie-break bits for the MinBD arbiters.
// Latency 1 cycle; no backpressure, en=0 freezes the output registers while epoch/LFSR keep running.
module gold_silver_tagger #(
  parameter int          NUM_PORT    = 4,
  parameter int          WIDTH_NODE  = 4,
  parameter int          NUM_NODE    = 16,
  parameter int          WIDTH_PKTID = 3,
  parameter int          GOLD_EPOCH  = 64,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en,
  input  logic [NUM_PORT-1:0]             in_vld,
  input  logic [NUM_PORT*WIDTH_NODE-1:0]  in_src,
  input  logic [NUM_PORT*WIDTH_PKTID-1:0] in_pkt,
  output logic [NUM_PORT-1:0]             out_vld,
  output logic [NUM_PORT-1:0]             out_gold,
  output logic [NUM_PORT-1:0]             out_silver,
  output logic [NUM_PORT-1:0]             rand_num,
  output logic [WIDTH_NODE-1:0]           gold_src,
  output logic [WIDTH_PKTID-1:0]          gold_pkt
);

  localparam int PORT_W  = $clog2(NUM_PORT);
  localparam int EPOCH_W = $clog2(GOLD_EPOCH);
  localparam logic [15:0]            SEED       = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [EPOCH_W-1:0]     EPOCH_LAST = EPOCH_W'(GOLD_EPOCH - 1);
  localparam logic [WIDTH_NODE-1:0]  NODE_LAST  = WIDTH_NODE'(NUM_NODE - 1);

  logic [EPOCH_W-1:0]  epoch_cnt;
  logic [15:0]         lfsr;
  logic                lfsr_fb;
  logic [NUM_PORT-1:0] gold_c;
  logic [NUM_PORT-1:0] elig;
  logic [NUM_PORT-1:0] silver_c;
  logic [NUM_PORT-1:0] rand_c;
  logic [PORT_W-1:0]   start_idx;

  // Taps 16,14,13,11 in right-shift form; a nonzero seed can never reach 0.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epoch_cnt <= '0;
      gold_src  <= '0;
      gold_pkt  <= '0;
      lfsr      <= SEED;
    end else begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
      if (epoch_cnt == EPOCH_LAST) begin
        epoch_cnt <= '0;
        gold_pkt  <= gold_pkt + WIDTH_PKTID'(1);
        if (&gold_pkt) begin
          gold_src <= (gold_src == NODE_LAST) ? '0 : gold_src + WIDTH_NODE'(1);
        end
      end else begin
        epoch_cnt <= epoch_cnt + EPOCH_W'(1);
      end
    end
  end

  always_comb begin
    gold_c = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      gold_c[i] = in_vld[i]
                && (in_src[i*WIDTH_NODE +: WIDTH_NODE] == gold_src)
                && (in_pkt[i*WIDTH_PKTID +: WIDTH_PKTID] == gold_pkt);
    end
  end

  assign elig      = in_vld & ~gold_c;
  assign start_idx = lfsr[PORT_W-1:0];
  assign rand_c    = lfsr[NUM_PORT+3:4];

  // Round-robin style scan starting at a random port; index wraps naturally (power-of-2 ports).
  always_comb begin
    logic              found;
    logic [PORT_W-1:0] idx;
    silver_c = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      idx = start_idx + PORT_W'(k);
      if (!found && elig[idx]) begin
        silver_c[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld    <= '0;
      out_gold   <= '0;
      out_silver <= '0;
      rand_num   <= '0;
    end else if (en) begin
      out_vld    <= in_vld;
      out_gold   <= gold_c;
      out_silver <= silver_c;
      rand_num   <= rand_c;
    end
  end

endmodule

// File: tb/tb_gold_silver_tagger.sv
// Randomized bench for gold_silver_tagger against a cycle-count based reference model.
module tb_gold_silver_tagger;

  localparam int NP = 4;
  localparam int WN = 4;
  localparam int NN = 16;
  localparam int WP = 3;
  localparam int GE = 8;
  localparam int TAPS [4] = '{16, 14, 13, 11};

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic [NP-1:0]    in_vld = '0;
  logic [NP*WN-1:0] in_src = '0;
  logic [NP*WP-1:0] in_pkt = '0;
  logic [NP-1:0]    out_vld, out_gold, out_silver, rand_num;
  logic [WN-1:0]    gold_src;
  logic [WP-1:0]    gold_pkt;

  always #5 clk = ~clk;

  gold_silver_tagger #(
    .NUM_PORT(NP), .WIDTH_NODE(WN), .NUM_NODE(NN), .WIDTH_PKTID(WP),
    .GOLD_EPOCH(GE), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .in_vld(in_vld), .in_src(in_src), .in_pkt(in_pkt),
    .out_vld(out_vld), .out_gold(out_gold), .out_silver(out_silver),
    .rand_num(rand_num), .gold_src(gold_src), .gold_pkt(gold_pkt)
  );

  int checks = 0;
  int failures = 0;

  // Model state: clock edges since reset, LFSR value, and held expected outputs.
  int            cyc;
  logic [15:0]   m_lfsr;
  logic [NP-1:0] e_vld, e_gold, e_sil, e_rand;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cyc=%0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int m_gsrc();
    return (cyc / (GE * (1 << WP))) % NN;
  endfunction

  function automatic int m_gpkt();
    return (cyc / GE) % (1 << WP);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = 1'b0;
    for (int j = 0; j < 4; j++) fb = fb ^ v[16 - TAPS[j]];
    return {fb, v[15:1]};
  endfunction

  task automatic check_all(input string pfx);
    chk({pfx, "_vld"},    out_vld,    e_vld);
    chk({pfx, "_gold"},   out_gold,   e_gold);
    chk({pfx, "_silver"}, out_silver, e_sil);
    chk({pfx, "_rand"},   rand_num,   e_rand);
    chk({pfx, "_gsrc"},   gold_src,   m_gsrc());
    chk({pfx, "_gpkt"},   gold_pkt,   m_gpkt());
  endtask

  // Drive one cycle of inputs, advance one clock edge, compare against the model.
  task automatic step(input logic e, input logic [NP-1:0] v,
                      input logic [NP*WN-1:0] s, input logic [NP*WP-1:0] p);
    int gs, gp, st, q;
    logic [NP-1:0] g, sl;
    en = e; in_vld = v; in_src = s; in_pkt = p;
    if (e) begin
      gs = m_gsrc(); gp = m_gpkt();
      g = '0; sl = '0;
      for (int i = 0; i < NP; i++)
        if (v[i] && int'(s[i*WN +: WN]) == gs && int'(p[i*WP +: WP]) == gp) g[i] = 1'b1;
      st = int'(m_lfsr) % NP;
      for (int k = 0; k < NP; k++) begin
        q = (st + k) % NP;
        if (v[q] && !g[q]) begin
          sl[q] = 1'b1;
          break;
        end
      end
      e_vld = v; e_gold = g; e_sil = sl; e_rand = m_lfsr[7:4];
    end
    @(posedge clk); #1;
    cyc++;
    m_lfsr = lfsr_next(m_lfsr);
    check_all("step");
  endtask

  task automatic rand_step(input int en_pct);
    logic [NP-1:0]    v;
    logic [NP*WN-1:0] s;
    logic [NP*WP-1:0] p;
    v = NP'($urandom);
    for (int i = 0; i < NP; i++) begin
      s[i*WN +: WN] = ($urandom_range(0, 1) == 1) ? WN'(m_gsrc()) : WN'($urandom);
      p[i*WP +: WP] = ($urandom_range(0, 1) == 1) ? WP'(m_gpkt()) : WP'($urandom);
    end
    step(($urandom_range(0, 99) < en_pct), v, s, p);
  endtask

  task automatic run_until(input int target);
    while (cyc < target) rand_step(90);
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; in_vld = '0; in_src = '0; in_pkt = '0;
    cyc = 0; m_lfsr = 16'hACE1;
    e_vld = '0; e_gold = '0; e_sil = '0; e_rand = '0;
    @(posedge clk); #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_first_cycle(input string tag);
    step(1'b1, 4'b1111, 16'h3333, 12'h000);
    chk({tag, "_vld"},    out_vld,    4'b1111);
    chk({tag, "_gold"},   out_gold,   4'b0000);
    chk({tag, "_silver"}, out_silver, 4'b0010);
    chk({tag, "_rand"},   rand_num,   4'hE);
  endtask

  logic [NP-1:0] hold_vld, hold_gold, hold_sil, hold_rand;

  initial begin
    do_reset();
    test_first_cycle("t1");

    // Two gold flits of the same packet, no eligible silver.
    step(1'b1, 4'b0101, 16'h0000, 12'h000);
    chk("t3_gold",   out_gold,   4'b0101);
    chk("t3_silver", out_silver, 4'b0000);

    while (cyc < 7) step(1'b1, 4'b0000, 16'h0, 12'h0);
    // Arrives at epoch_cnt==7: matched against the pre-increment golden packet.
    step(1'b1, 4'b0001, 16'h0000, 12'h000);
    chk("t4_gold0", out_gold[0], 1'b1);
    chk("t4_gpkt",  gold_pkt,    3'd1);
    chk("t2_gsrc8", gold_src,    4'd0);

    run_until(64);
    chk("t2_gpkt64", gold_pkt, 3'd0);
    chk("t2_gsrc64", gold_src, 4'd1);

    run_until(70);
    hold_vld = out_vld; hold_gold = out_gold; hold_sil = out_silver; hold_rand = rand_num;
    for (int n = 0; n < 3; n++) begin
      step(1'b0, NP'($urandom), NP*WN'($urandom), NP*WP'($urandom));
      chk("t5_hold_vld",    out_vld,    hold_vld);
      chk("t5_hold_gold",   out_gold,   hold_gold);
      chk("t5_hold_silver", out_silver, hold_sil);
      chk("t5_hold_rand",   rand_num,   hold_rand);
    end
    chk("t5_gpkt", gold_pkt, 3'd1);

    run_until(16 * 64);
    chk("t2_gsrc_wrap", gold_src, 4'd0);
    chk("t2_gpkt_wrap", gold_pkt, 3'd0);

    run_until(16 * 64 + 5 * GE + 2);
    chk("t6_pre_gpkt", gold_pkt, 3'd5);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_vld",    out_vld,    4'b0000);
    chk("t6_async_gold",   out_gold,   4'b0000);
    chk("t6_async_silver", out_silver, 4'b0000);
    chk("t6_async_rand",   rand_num,   4'b0000);
    chk("t6_async_gsrc",   gold_src,   4'd0);
    chk("t6_async_gpkt",   gold_pkt,   3'd0);
    do_reset();
    test_first_cycle("t6_rerun");
    run_until(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
